// File: rtl/risc_toy_fetch.sv
// Instruction fetch front end: issues word requests to a one-cycle memory and
// queues returned words in a 2-entry buffer for decode; redirects flush and refetch.
module risc_toy_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        FETCH_EN,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        FD_READY,
  output logic        FD_VALID,
  output logic [31:0] FD_INSTR,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_NPC
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  localparam logic [31:0] BOOT_PC = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] head_instr, head_pc, tail_instr, tail_pc;

  logic        redir, pop, push;
  logic [31:0] redir_pc, fetch_pc;
  logic [2:0]  occ;

  assign FD_VALID = (count != 2'd0);
  assign FD_INSTR = head_instr;
  assign FD_PC    = head_pc;
  assign FD_NPC   = head_pc + 32'd4;

  always_comb begin
    redir    = REDIRECT && (state != BOOT);
    redir_pc = REDIRECT_PC & 32'hFFFF_FFFC;
    fetch_pc = (state == RUN && REDIRECT) ? redir_pc : pc;
    pop      = FD_VALID && FD_READY && !redir;
    push     = inflight && !redir;
    // occupancy the buffer will have once the outstanding word lands
    occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    IREQ     = RSTN && (state == RUN) && (REDIRECT || (occ < 3'd2));
    IADDR    = RSTN ? fetch_pc[31:2] : BOOT_PC[31:2];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= BOOT;
      pc         <= BOOT_PC;
      if_pc      <= 32'd0;
      inflight   <= 1'b0;
      count      <= 2'd0;
      head_instr <= 32'd0;
      head_pc    <= 32'd0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
    end else begin
      case (state)
        BOOT:    state <= FETCH_EN ? RUN : PAUSE;
        RUN:     if (!FETCH_EN) state <= PAUSE;
        PAUSE:   if (FETCH_EN) state <= RUN;
        default: state <= BOOT;
      endcase

      if (IREQ) begin
        pc       <= fetch_pc + 32'd4;
        if_pc    <= fetch_pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
        if (redir) pc <= redir_pc;
      end

      // head is always entry 0 so decode sees a straight register
      if (redir) begin
        count <= 2'd0;
      end else if (push && pop) begin
        if (count == 2'd1) begin
          head_instr <= INSTR;
          head_pc    <= if_pc;
        end else begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          tail_instr <= INSTR;
          tail_pc    <= if_pc;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head_instr <= INSTR;
          head_pc    <= if_pc;
        end else begin
          tail_instr <= INSTR;
          tail_pc    <= if_pc;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
        count      <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: two instances (default and wrap-around reset PC)
// fed by one-cycle memories returning address-tagged words.
module tb_risc_toy_fetch;

  logic        CLK = 1'b0;
  logic        RSTN, FETCH_EN, REDIRECT, FD_READY;
  logic [31:0] REDIRECT_PC;

  logic        IREQ, FD_VALID;
  logic [29:0] IADDR;
  logic [31:0] INSTR, FD_INSTR, FD_PC, FD_NPC;
  logic        w_IREQ, w_FD_VALID;
  logic [29:0] w_IADDR;
  logic [31:0] w_INSTR, w_FD_INSTR, w_FD_PC, w_FD_NPC;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hC3C3_0000;
  endfunction

  logic        m_vld = 1'b0, wm_vld = 1'b0;
  logic [29:0] m_addr = '0, wm_addr = '0;
  always @(posedge CLK) begin
    m_vld   <= IREQ;
    m_addr  <= IADDR;
    wm_vld  <= w_IREQ;
    wm_addr <= w_IADDR;
  end
  assign INSTR   = m_vld  ? word_of(m_addr)  : 32'hDEAD_BEEF;
  assign w_INSTR = wm_vld ? word_of(wm_addr) : 32'hDEAD_BEEF;

  risc_toy_fetch dut (
    .CLK(CLK), .RSTN(RSTN), .FETCH_EN(FETCH_EN), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .FD_READY(FD_READY), .FD_VALID(FD_VALID), .FD_INSTR(FD_INSTR),
    .FD_PC(FD_PC), .FD_NPC(FD_NPC)
  );

  risc_toy_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(CLK), .RSTN(RSTN), .FETCH_EN(FETCH_EN), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IREQ(w_IREQ), .IADDR(w_IADDR), .INSTR(w_INSTR),
    .FD_READY(FD_READY), .FD_VALID(w_FD_VALID), .FD_INSTR(w_FD_INSTR),
    .FD_PC(w_FD_PC), .FD_NPC(w_FD_NPC)
  );

  task automatic test_reset();
    RSTN = 1'b0; FETCH_EN = 1'b1; FD_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;
    repeat (2) @(negedge CLK);
    #1;
    n_tests++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL reset_ireq got %b want 0", IREQ); end
    n_tests++; if (IADDR !== 30'd0) begin n_fail++; $display("FAIL reset_iaddr got %h want 0", IADDR); end
    n_tests++; if (FD_VALID !== 1'b0 || FD_INSTR !== 32'd0 || FD_PC !== 32'd0 || FD_NPC !== 32'd4) begin
      n_fail++; $display("FAIL reset_fd got v=%b i=%h pc=%h npc=%h want 0/0/0/4", FD_VALID, FD_INSTR, FD_PC, FD_NPC); end
    n_tests++; if (w_IADDR !== 30'h3FFF_FFFE) begin n_fail++; $display("FAIL reset_w_iaddr got %h want 3ffffffe", w_IADDR); end
    // BOOT cycle: RSTN high but state still BOOT
    RSTN = 1'b1;
    #1;
    n_tests++; if (IREQ !== 1'b0 || FD_VALID !== 1'b0) begin
      n_fail++; $display("FAIL boot_idle got ireq=%b v=%b want 0/0", IREQ, FD_VALID); end
    n_tests++; if (IADDR !== 30'd0) begin n_fail++; $display("FAIL boot_iaddr got %h want 0", IADDR); end
  endtask

  task automatic test_stream();
    exp_pc = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK); #1;
      n_tests++; if (IREQ !== 1'b1 || IADDR !== 30'(k - 1)) begin
        n_fail++; $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, IREQ, IADDR, 30'(k - 1)); end
      n_tests++; if (FD_VALID !== (k >= 3)) begin
        n_fail++; $display("FAIL stream_valid k=%0d got %b want %b", k, FD_VALID, (k >= 3)); end
      if (FD_VALID && FD_READY && !REDIRECT) begin
        n_tests++; if (FD_PC !== exp_pc || FD_NPC !== exp_pc + 32'd4 || FD_INSTR !== word_of(exp_pc[31:2])) begin
          n_fail++; $display("FAIL stream_data got %h/%h/%h want pc %h", FD_PC, FD_NPC, FD_INSTR, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 5; s++) begin
      @(negedge CLK); FD_READY = 1'b0; #1;
      n_tests++; if (IREQ !== 1'b0) begin n_fail++; $display("FAIL stall_ireq s=%0d got %b want 0", s, IREQ); end
      n_tests++; if (FD_VALID !== 1'b1 || FD_PC !== exp_pc) begin
        n_fail++; $display("FAIL stall_head s=%0d got %b/%h want 1/%h", s, FD_VALID, FD_PC, exp_pc); end
    end
    for (int s = 5; s < 13; s++) begin
      @(negedge CLK); FD_READY = 1'b1; #1;
      n_tests++; if (IREQ !== 1'b1 || FD_VALID !== 1'b1) begin
        n_fail++; $display("FAIL resume_flow s=%0d got ireq=%b v=%b want 1/1", s, IREQ, FD_VALID); end
      if (s == 5) begin
        n_tests++; if (IADDR !== 30'd8) begin n_fail++; $display("FAIL resume_iaddr got %h want 8", IADDR); end
      end
      if (FD_VALID && FD_READY && !REDIRECT) begin
        n_tests++; if (FD_PC !== exp_pc || FD_NPC !== exp_pc + 32'd4 || FD_INSTR !== word_of(exp_pc[31:2])) begin
          n_fail++; $display("FAIL resume_data got %h/%h/%h want pc %h", FD_PC, FD_NPC, FD_INSTR, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_redirect();
    @(negedge CLK); REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0103; #1;
    n_tests++; if (IREQ !== 1'b1 || IADDR !== 30'h40) begin
      n_fail++; $display("FAIL redir_req got %b/%h want 1/40", IREQ, IADDR); end
    @(negedge CLK); REDIRECT = 1'b0; #1;
    n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %b want 0", FD_VALID); end
    n_tests++; if (IREQ !== 1'b1 || IADDR !== 30'h41) begin
      n_fail++; $display("FAIL redir_next got %b/%h want 1/41", IREQ, IADDR); end
    exp_pc = 32'h0000_0100;
    for (int r = 2; r < 6; r++) begin
      @(negedge CLK); #1;
      n_tests++; if (FD_VALID !== 1'b1) begin n_fail++; $display("FAIL redir_valid r=%0d got %b want 1", r, FD_VALID); end
      if (FD_VALID && FD_READY && !REDIRECT) begin
        n_tests++; if (FD_PC !== exp_pc || FD_NPC !== exp_pc + 32'd4 || FD_INSTR !== word_of(exp_pc[31:2])) begin
          n_fail++; $display("FAIL redir_data got %h/%h/%h want pc %h", FD_PC, FD_NPC, FD_INSTR, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_pause();
    logic        e_ireq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        e_vld  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int p = 0; p < 7; p++) begin
      @(negedge CLK);
      FETCH_EN = (p >= 3);
      REDIRECT = (p == 3);
      REDIRECT_PC = 32'h0000_0200;
      #1;
      n_tests++; if (IREQ !== e_ireq[p] || FD_VALID !== e_vld[p]) begin
        n_fail++; $display("FAIL pause p=%0d got ireq=%b v=%b want %b/%b", p, IREQ, FD_VALID, e_ireq[p], e_vld[p]); end
      if (p == 4) begin
        n_tests++; if (IADDR !== 30'h80) begin n_fail++; $display("FAIL pause_iaddr got %h want 80", IADDR); end
        exp_pc = 32'h0000_0200;
      end
      if (FD_VALID && FD_READY && !REDIRECT) begin
        n_tests++; if (FD_PC !== exp_pc || FD_NPC !== exp_pc + 32'd4 || FD_INSTR !== word_of(exp_pc[31:2])) begin
          n_fail++; $display("FAIL pause_data p=%0d got %h/%h/%h want pc %h", p, FD_PC, FD_NPC, FD_INSTR, exp_pc); end
        exp_pc += 32'd4;
      end
    end
    REDIRECT = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); FD_READY = 1'b0;
    @(negedge CLK); RSTN = 1'b0; #1;
    n_tests++; if (FD_VALID !== 1'b1 || IREQ !== 1'b0 || IADDR !== 30'd0) begin
      n_fail++; $display("FAIL rmid_pre got v=%b ireq=%b iaddr=%h want 1/0/0", FD_VALID, IREQ, IADDR); end
    @(negedge CLK); RSTN = 1'b1; FD_READY = 1'b1; #1;
    n_tests++; if (FD_VALID !== 1'b0 || IREQ !== 1'b0 || FD_PC !== 32'd0 || FD_INSTR !== 32'd0) begin
      n_fail++; $display("FAIL rmid_boot got v=%b ireq=%b pc=%h i=%h want 0/0/0/0", FD_VALID, IREQ, FD_PC, FD_INSTR); end
    exp_pc = 32'd0;
    for (int q = 1; q <= 4; q++) begin
      @(negedge CLK); #1;
      n_tests++; if (IREQ !== 1'b1 || IADDR !== 30'(q - 1) || FD_VALID !== (q >= 3)) begin
        n_fail++; $display("FAIL rmid_restart q=%0d got %b/%h/%b want 1/%h/%b", q, IREQ, IADDR, FD_VALID, 30'(q - 1), (q >= 3)); end
      if (FD_VALID && FD_READY && !REDIRECT) begin
        n_tests++; if (FD_PC !== exp_pc || FD_NPC !== exp_pc + 32'd4 || FD_INSTR !== word_of(exp_pc[31:2])) begin
          n_fail++; $display("FAIL rmid_data got %h/%h/%h want pc %h", FD_PC, FD_NPC, FD_INSTR, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_wrap();
    logic [29:0] e_ia [5] = '{30'h3FFF_FFFE, 30'h3FFF_FFFF, 30'h0, 30'h1, 30'h2};
    logic [31:0] e_pc [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] e_np [5] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    @(negedge CLK); RSTN = 1'b0;
    @(negedge CLK); RSTN = 1'b1; #1;
    n_tests++; if (w_IREQ !== 1'b0 || w_IADDR !== 30'h3FFF_FFFE) begin
      n_fail++; $display("FAIL wrap_boot got %b/%h want 0/3ffffffe", w_IREQ, w_IADDR); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      n_tests++; if (w_IREQ !== 1'b1 || w_IADDR !== e_ia[k]) begin
        n_fail++; $display("FAIL wrap_req k=%0d got %b/%h want 1/%h", k, w_IREQ, w_IADDR, e_ia[k]); end
      n_tests++; if (w_FD_VALID !== (k >= 2)) begin
        n_fail++; $display("FAIL wrap_valid k=%0d got %b want %b", k, w_FD_VALID, (k >= 2)); end
      if (k >= 2) begin
        n_tests++; if (w_FD_PC !== e_pc[k] || w_FD_NPC !== e_np[k] || w_FD_INSTR !== word_of(e_pc[k][31:2])) begin
          n_fail++; $display("FAIL wrap_data k=%0d got %h/%h/%h want %h/%h", k, w_FD_PC, w_FD_NPC, w_FD_INSTR, e_pc[k], e_np[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_pause();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
